// File: rtl/rec_timer_if.sv
// Command/status bundle for the record/playback timer.
// Commands are single-cycle pulses with no handshake: a pulse is consumed on the edge that samples it.
interface rec_timer_if;
  logic       i_start_rec;
  logic       i_start_play;
  logic       i_pause;
  logic       i_stop;
  logic [5:0] o_sec;
  logic [5:0] o_rec_len;
  logic [1:0] o_state;
  logic       o_done;

  modport master (
    output i_start_rec, i_start_play, i_pause, i_stop,
    input  o_sec, o_rec_len, o_state, o_done
  );

  modport slave (
    input  i_start_rec, i_start_play, i_pause, i_stop,
    output o_sec, o_rec_len, o_state, o_done
  );
endinterface

// File: rtl/rec_timer.sv
// Record/playback seconds timer: prescaled seconds counter driven by a four-state FSM,
// remembering the length of the last completed recording.
module rec_timer #(
  parameter int CLK_HZ  = 12000000,
  parameter int MAX_SEC = 31
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  rec_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REC   = 2'd1,
    S_PLAY  = 2'd2,
    S_PAUSE = 2'd3
  } state_e;

  localparam int            PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [5:0]    SEC_MAX    = 6'(MAX_SEC);

  state_e        state_q, state_d;
  state_e        resume_q, resume_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    rec_len_q, rec_len_d;
  logic          done_q, done_d;

  logic       cmd_stop, cmd_pause, cmd_rec, cmd_play;
  logic       running, tick, natural_end, play_ok;
  logic [5:0] sec_inc;

  // Strict priority: a higher command masks all lower pulses in the same cycle.
  always_comb begin
    cmd_stop    = bus.i_stop;
    cmd_pause   = bus.i_pause & ~bus.i_stop;
    cmd_rec     = bus.i_start_rec & ~bus.i_pause & ~bus.i_stop;
    cmd_play    = bus.i_start_play & ~bus.i_start_rec & ~bus.i_pause & ~bus.i_stop;
    play_ok     = cmd_play & (rec_len_q != 6'd0);
    running     = (state_q == S_REC) || (state_q == S_PLAY);
    tick        = running && (presc_q == PRESC_LAST);
    sec_inc     = sec_q + 6'd1;
    // A command in the tick cycle swallows the tick.
    natural_end = tick && !cmd_stop && !cmd_pause &&
                  ((state_q == S_REC) ? (sec_inc >= SEC_MAX) : (sec_inc >= rec_len_q));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      resume_q  <= S_REC;
      presc_q   <= '0;
      sec_q     <= 6'd0;
      rec_len_q <= 6'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      resume_q  <= resume_d;
      presc_q   <= presc_d;
      sec_q     <= sec_d;
      rec_len_q <= rec_len_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_rec)      state_d = S_REC;
        else if (play_ok) state_d = S_PLAY;
      end
      S_REC, S_PLAY: begin
        if (cmd_stop) state_d = S_IDLE;
        else if (cmd_pause) begin
          state_d  = S_PAUSE;
          resume_d = state_q;
        end else if (natural_end) state_d = S_IDLE;
      end
      S_PAUSE: begin
        if (cmd_stop)       state_d = S_IDLE;
        else if (cmd_pause) state_d = resume_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    presc_d   = presc_q;
    sec_d     = sec_q;
    rec_len_d = rec_len_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        if (cmd_rec || play_ok) sec_d = 6'd0;
      end
      S_REC, S_PLAY: begin
        if (cmd_stop) begin
          presc_d = '0;
          if (state_q == S_REC) rec_len_d = sec_q;
        end else if (cmd_pause) begin
          presc_d = presc_q;
        end else if (tick) begin
          presc_d = '0;
          sec_d   = sec_inc;
          if (natural_end) begin
            done_d = 1'b1;
            if (state_q == S_REC) rec_len_d = SEC_MAX;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      S_PAUSE: begin
        if (cmd_stop) begin
          presc_d = '0;
          if (resume_q == S_REC) rec_len_d = sec_q;
        end
      end
      default: presc_d = '0;
    endcase
  end

  always_comb begin
    bus.o_state   = state_q;
    bus.o_sec     = sec_q;
    bus.o_rec_len = rec_len_q;
    bus.o_done    = done_q;
  end

endmodule

// File: tb/tb_rec_timer.sv
// Directed bench for rec_timer with CLK_HZ=4, MAX_SEC=31: a cycle-step vector table
// followed by hand-written reset sequences.
module tb_rec_timer;

  logic clk;
  logic rst_n;

  rec_timer_if bus ();

  rec_timer #(.CLK_HZ(4), .MAX_SEC(31)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // cmd bits: [3]=start_rec [2]=start_play [1]=pause [0]=stop
  typedef struct {
    logic [3:0] cmd;
    int         waits;
    logic [1:0] st;
    logic [5:0] sec;
    logic [5:0] len;
    int         dn;
  } vec_t;

  localparam int NV = 37;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    else pass_cnt++;
  endtask

  task automatic drive(input logic [3:0] cmd);
    bus.i_start_rec  = cmd[3];
    bus.i_start_play = cmd[2];
    bus.i_pause      = cmd[1];
    bus.i_stop       = cmd[0];
  endtask

  // Apply cmd for one edge, then idle for `waits` edges; count o_done samples.
  task automatic step(input logic [3:0] cmd, input int waits, output int dn);
    dn = 0;
    drive(cmd);
    @(posedge clk);
    @(negedge clk);
    drive(4'b0000);
    if (bus.o_done) dn++;
    for (int k = 0; k < waits; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.o_done) dn++;
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] st, input logic [5:0] sec,
                            input logic [5:0] len);
    chk({tag, ".state"},   32'(bus.o_state),   32'(st));
    chk({tag, ".sec"},     32'(bus.o_sec),     32'(sec));
    chk({tag, ".rec_len"}, 32'(bus.o_rec_len), 32'(len));
  endtask

  initial begin
    int dn;
    vecs[0]  = '{4'b0100,   0, 2'd0, 6'd0,  6'd0,  0}; // play with empty recording
    vecs[1]  = '{4'b1001,   0, 2'd0, 6'd0,  6'd0,  0}; // stop masks start_rec
    vecs[2]  = '{4'b0010,   0, 2'd0, 6'd0,  6'd0,  0}; // pause in idle
    vecs[3]  = '{4'b1000,   0, 2'd1, 6'd0,  6'd0,  0};
    vecs[4]  = '{4'b0000,  11, 2'd1, 6'd3,  6'd0,  0};
    vecs[5]  = '{4'b0001,   0, 2'd0, 6'd3,  6'd3,  0};
    vecs[6]  = '{4'b0100,   0, 2'd2, 6'd0,  6'd3,  0};
    vecs[7]  = '{4'b0000,   3, 2'd2, 6'd1,  6'd3,  0};
    vecs[8]  = '{4'b0000,   3, 2'd2, 6'd2,  6'd3,  0};
    vecs[9]  = '{4'b0000,   3, 2'd0, 6'd3,  6'd3,  1};
    vecs[10] = '{4'b1100,   0, 2'd1, 6'd0,  6'd3,  0}; // rec beats play
    vecs[11] = '{4'b0100,   0, 2'd1, 6'd0,  6'd3,  0}; // play ignored in REC
    vecs[12] = '{4'b0000,   7, 2'd1, 6'd2,  6'd3,  0}; // sec=2, prescaler=1
    vecs[13] = '{4'b0010,   0, 2'd3, 6'd2,  6'd3,  0};
    vecs[14] = '{4'b0000,  49, 2'd3, 6'd2,  6'd3,  0};
    vecs[15] = '{4'b1010,   0, 2'd1, 6'd2,  6'd3,  0}; // resume, start_rec dropped
    vecs[16] = '{4'b0000,   1, 2'd1, 6'd2,  6'd3,  0};
    vecs[17] = '{4'b0000,   0, 2'd1, 6'd3,  6'd3,  0}; // third edge after resume
    vecs[18] = '{4'b0000,   3, 2'd1, 6'd4,  6'd3,  0};
    vecs[19] = '{4'b0010,   0, 2'd3, 6'd4,  6'd3,  0};
    vecs[20] = '{4'b0011,   0, 2'd0, 6'd4,  6'd4,  0}; // stop from paused REC
    vecs[21] = '{4'b0100,   0, 2'd2, 6'd0,  6'd4,  0};
    vecs[22] = '{4'b0010,   0, 2'd3, 6'd0,  6'd4,  0};
    vecs[23] = '{4'b0100,   0, 2'd3, 6'd0,  6'd4,  0};
    vecs[24] = '{4'b0001,   0, 2'd0, 6'd0,  6'd4,  0}; // stop from paused PLAY
    vecs[25] = '{4'b1000,   0, 2'd1, 6'd0,  6'd4,  0};
    vecs[26] = '{4'b0000, 123, 2'd0, 6'd31, 6'd31, 1}; // full-length recording
    vecs[27] = '{4'b0000,   2, 2'd0, 6'd31, 6'd31, 0};
    vecs[28] = '{4'b0100,   0, 2'd2, 6'd0,  6'd31, 0};
    vecs[29] = '{4'b0000,   2, 2'd2, 6'd0,  6'd31, 0}; // prescaler at last count
    vecs[30] = '{4'b0010,   0, 2'd3, 6'd0,  6'd31, 0}; // pause swallows tick
    vecs[31] = '{4'b0010,   0, 2'd2, 6'd0,  6'd31, 0};
    vecs[32] = '{4'b0000,   0, 2'd2, 6'd1,  6'd31, 0};
    vecs[33] = '{4'b0001,   0, 2'd0, 6'd1,  6'd31, 0};
    vecs[34] = '{4'b0100,   0, 2'd2, 6'd0,  6'd31, 0};
    vecs[35] = '{4'b0000,   2, 2'd2, 6'd0,  6'd31, 0};
    vecs[36] = '{4'b0001,   0, 2'd0, 6'd0,  6'd31, 0}; // stop swallows tick

    rst_n = 1'b0;
    drive(4'b0000);
    repeat (3) @(negedge clk);
    check_outs("reset", 2'd0, 6'd0, 6'd0);
    chk("reset.done", 32'(bus.o_done), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      step(vecs[i].cmd, vecs[i].waits, dn);
      check_outs(tag, vecs[i].st, vecs[i].sec, vecs[i].len);
      chk({tag, ".done_cnt"}, 32'(dn), 32'(vecs[i].dn));
    end

    // Asynchronous reset in the middle of playback, between edges.
    step(4'b0100, 0, dn);
    step(4'b0000, 5, dn);
    check_outs("pre_rst", 2'd2, 6'd1, 6'd31);
    #2 rst_n = 1'b0;
    #1;
    check_outs("async_rst", 2'd0, 6'd0, 6'd0);
    chk("async_rst.done", 32'(bus.o_done), 32'd0);

    // Command accepted on the first edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1000, 5, dn);
    check_outs("post_rst", 2'd1, 6'd1, 6'd0);

    // Reset mid-REC discards the in-progress length.
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0100, 0, dn);
    check_outs("rst_rec_len", 2'd0, 6'd0, 6'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rec_timer.md
REC_TIMER -- requirements
Module: rec_timer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 12000000, input clock cycles per elapsed second.
REQ-002 The block SHALL have parameter MAX_SEC, default 31, maximum displayable seconds (range 1..63).
REQ-003 The block SHALL have port i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 The block SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_start_rec  input  1  one-cycle pulse, begin recording timer.
REQ-006 The block SHALL have port i_start_play  input  1  one-cycle pulse, begin playback timer.
REQ-007 The block SHALL have port i_pause  input  1  one-cycle pulse, toggle pause/resume.
REQ-008 The block SHALL have port i_stop  input  1  one-cycle pulse, abort current operation.
REQ-009 The block SHALL have port o_sec  output  6  elapsed seconds, binary 0..MAX_SEC, feeds the two-digit seven-segment decoder directly.
REQ-010 The block SHALL have port o_rec_len  output  6  length of last completed recording, seconds.
REQ-011 The block SHALL have port o_state  output  2  0=IDLE, 1=REC, 2=PLAY, 3=PAUSE.
REQ-012 The block SHALL have port o_done  output  1  one-cycle pulse on natural end of REC or PLAY.

Function
REQ-013 FSM states SHALL be IDLE, REC, PLAY, PAUSE; a resume register SHALL hold the mode (REC/PLAY) active on entering PAUSE.
REQ-014 Command priority within one cycle SHALL be i_stop > i_pause > i_start_rec > i_start_play; lower-priority pulses in the same cycle are discarded.
REQ-015 IDLE + i_start_rec SHALL enter REC next cycle with o_sec=0 and prescaler=0.
REQ-016 IDLE + i_start_play SHALL enter PLAY with o_sec=0, prescaler=0 only if o_rec_len != 0; otherwise ignored, state stays IDLE.
REQ-017 Prescaler SHALL count 0..CLK_HZ-1 in REC and PLAY, hold its value in PAUSE, and clear in IDLE.
REQ-018 A tick SHALL occur in the cycle prescaler==CLK_HZ-1; prescaler wraps to 0; o_sec increments by 1 on the following edge (latency: CLK_HZ cycles from start to o_sec=1).
REQ-019 REC: when the tick makes o_sec equal MAX_SEC, SHALL load o_rec_len=MAX_SEC, return to IDLE, pulse o_done for one cycle; o_sec holds MAX_SEC.
REQ-020 PLAY: when the tick makes o_sec equal o_rec_len, SHALL return to IDLE and pulse o_done; o_sec holds final value.
REQ-021 REC/PLAY + i_pause SHALL enter PAUSE; PAUSE + i_pause SHALL return to the saved mode with prescaler and o_sec unchanged.
REQ-022 i_start_rec and i_start_play SHALL be ignored in REC, PLAY and PAUSE.
REQ-023 i_stop in REC, or in PAUSE with saved mode REC, SHALL load o_rec_len=o_sec and enter IDLE; no o_done pulse.
REQ-024 i_stop in PLAY, or in PAUSE with saved mode PLAY, SHALL enter IDLE, o_rec_len unchanged; no o_done pulse.
REQ-025 i_stop and i_pause in IDLE SHALL have no effect.
REQ-026 A tick coinciding with i_stop or i_pause SHALL be discarded (command wins; o_sec not incremented).
REQ-027 o_sec SHALL never exceed MAX_SEC; o_sec and o_rec_len SHALL be 6-bit unsigned, no wrap.
REQ-028 o_sec SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-029 i_rst_n low SHALL immediately force state=IDLE, o_sec=0, o_rec_len=0, o_done=0, prescaler=0, resume register=REC, regardless of clock.
REQ-030 Reset asserted mid-REC/PLAY/PAUSE SHALL discard all progress, including the in-progress recording length.
REQ-031 After i_rst_n deasserts, the block SHALL accept a command on the first rising edge.

Verification (CLK_HZ=4, MAX_SEC=31 unless stated)
REQ-032 Reset, i_start_rec, wait 12 cycles, i_stop -> o_sec=3, o_rec_len=3, o_state=0, no o_done.
REQ-033 i_start_rec, run 124 cycles -> o_sec=31, o_rec_len=31, o_done high exactly one cycle, o_state=0.
REQ-034 o_rec_len=3, i_start_play -> o_sec 0,1,2,3 at 4-cycle spacing, o_done pulse when o_sec=3, then IDLE.
REQ-035 REC at o_sec=2 prescaler=1, i_pause, wait 50 cycles, i_pause -> o_sec stays 2 during pause; becomes 3 exactly 3 cycles after resume.
REQ-036 o_rec_len=0, i_start_play -> o_state stays 0; same-cycle i_stop+i_start_rec in IDLE -> stays IDLE.
REQ-037 Assert i_rst_n low mid-PLAY between edges -> outputs zero immediately, before next clock edge.
